ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Hazard controller for the 5-stage pipeline (IF ID EX MEM WB) around the integer ALU.
//  Tracks destination registers of in-flight instructions in EX, MEM and WB.
//  Drives the operand-forwarding selects for the ALU source operands os/ot.
//  Generates the load-use stall, the EX bubble and the ID squash on a taken jump/branch.
// PARAMETERS
//  REG_W   5  register-index width; 2**REG_W architectural registers, r0 hard-wired zero
//  FWD_EN  1  1: forward from MEM/WB; 0: no forwarding, stall ID until the writer reaches WB
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  id_valid    in   1      instruction present in ID
//  id_rs       in   REG_W  ID source register s
//  id_rt       in   REG_W  ID source register t
//  id_use_s    in   1      ID instruction reads rs
//  id_use_t    in   1      ID instruction reads rt
//  id_wreg     in   REG_W  ID destination register (rd, rt or 31 per opcode)
//  id_wen      in   1      ID instruction writes id_wreg
//  id_load     in   1      ID instruction is a load (data ready only in WB)
//  flush       in   1      taken jump/branch resolved in EX this cycle
//  mem_stall   in   1      data memory busy; freezes whole pipeline
//  stall_if_id out  1      hold PC and IF/ID latch
//  bubble_ex   out  1      load NOP into ID/EX latch
//  squash_id   out  1      kill IF and ID contents
//  fwd_s       out  2      os select for EX: 0 ID/EX latch, 1 MEM result, 2 WB result
//  fwd_t       out  2      ot select for EX, same encoding
//  wb_wreg     out  REG_W  WB destination register; 0 when WB invalid
//  wb_wen      out  1      register-file write enable for WB
// BEHAVIOUR
//  State: EX, MEM and WB records {valid, wreg, wen, load, rs, rt, use_s, use_t}.
//   rs/rt/use_* are kept in EX only.
//  Reset: all records invalid and zero.
//   stall_if_id, bubble_ex and squash_id are forced 0 while rst is high.
//   fwd_s=fwd_t=0, wb_wreg=0, wb_wen=0.
//  A record with wreg==0 never counts as a writer: no forwarding, no stall.
//  Register file is write-through: a WB write is visible to the ID read in the same cycle.
//  Advance on each clk when mem_stall=0:
//   WB<=MEM; MEM<=EX; EX<=ID, or an invalid record if bubble_ex or squash_id.
//  mem_stall=1:
//   All records hold; stall_if_id=1, bubble_ex=0, squash_id=0; flush is ignored.
//   The flush source holds flush until mem_stall drops.
//  Forwarding, combinational from registered state (FWD_EN=1):
//   fwd_s=1 if MEM.valid & MEM.wen & MEM.wreg==EX.rs & EX.use_s & EX.rs!=0.
//   Else fwd_s=2 on the same match against WB. Else 0. MEM beats WB. fwd_t likewise on rt.
//   FWD_EN=0: fwd_s and fwd_t are constant 0.
//  Load-use, FWD_EN=1:
//   hazard = id_valid & EX.valid & EX.load & EX.wen & EX.wreg!=0
//            & ((id_use_s & id_rs==EX.wreg) | (id_use_t & id_rt==EX.wreg)).
//   Stall is exactly 1 cycle; the consumer enters EX with the load in WB and gets fwd=2.
//  FWD_EN=0 hazard: any ID source matches a valid writer in EX or MEM (WB is covered by write-through).
//  On hazard with mem_stall=0 and flush=0: stall_if_id=1, bubble_ex=1.
//  flush with mem_stall=0: squash_id=1, and the ID instruction is not entered into EX.
//   flush overrides hazard: stall_if_id=0, bubble_ex=0 (a squashed instruction needs no stall).
//   The EX instruction carrying flush continues to MEM normally.
//  Reset mid-operation: all in-flight records are dropped at once; no write enable is issued afterwards.
//  Latency: forwarding selects are valid in the same cycle the consumer occupies EX.
// TESTING
//  add r3 in EX, then sub r4,r3,r3 in ID -> next cycle fwd_s=1, fwd_t=1, stall_if_id=0.
//  add r3, nop, or r5,r3,r1 -> or in EX with add in WB: fwd_s=2, fwd_t=0.
//  lw r7 in EX, add r8,r7,r2 in ID -> 1 cycle stall_if_id=bubble_ex=1; add then in EX with fwd_s=2.
//  add r0,r1,r2, then use of r0 -> no forwarding (fwd=0), no stall; load to r0 -> no stall.
//  Load-use hazard and flush in the same cycle -> squash_id=1, stall_if_id=0; ID is not entered into EX.
//  mem_stall held 3 cycles mid-stream -> records frozen, stall_if_id=1, fwd values unchanged.
//  Reset mid-stream -> wb_wen=0 next cycle. FWD_EN=0 with add r3 then use of r3 -> 2 stall cycles.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// Hazard control for the IF/ID/EX/MEM/WB integer pipeline: forwarding selects,
// load-use / no-forward stalls, EX bubbles and ID squash on a taken jump/branch.
module ex_hazard_ctrl #(
    parameter int REG_W  = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_s,
    input  logic             id_use_t,
    input  logic [REG_W-1:0] id_wreg,
    input  logic             id_wen,
    input  logic             id_load,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             squash_id,
    output logic [1:0]       fwd_s,
    output logic [1:0]       fwd_t,
    output logic [REG_W-1:0] wb_wreg,
    output logic             wb_wen
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wreg;
        logic             wen;
    } wr_rec_t;

    typedef struct packed {
        wr_rec_t          w;
        logic             load;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             use_s;
        logic             use_t;
    } ex_rec_t;

    ex_rec_t ex_q, ex_d;
    wr_rec_t mem_q, mem_d;
    wr_rec_t wb_q, wb_d;
    logic    hazard;

    // r0 writes never count as producers
    function automatic logic writes(input wr_rec_t r, input logic [REG_W-1:0] a);
        return r.valid & r.wen & (r.wreg != '0) & (r.wreg == a);
    endfunction

    function automatic logic id_hit(input wr_rec_t r);
        return (id_use_s & writes(r, id_rs)) | (id_use_t & writes(r, id_rt));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_x, input logic [REG_W-1:0] src);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_x & writes(mem_q, src))
            sel = 2'd1;
        else if (use_x & writes(wb_q, src))
            sel = 2'd2;
        return sel;
    endfunction

    always_comb begin
        if (FWD_EN)
            hazard = id_valid & ex_q.load & id_hit(ex_q.w);
        else
            hazard = id_valid & (id_hit(ex_q.w) | id_hit(mem_q));
    end

    // mem_stall freezes everything and masks flush; flush beats a hazard
    always_comb begin
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        squash_id   = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stall_if_id = 1'b1;
            end else if (flush) begin
                squash_id = 1'b1;
            end else if (hazard) begin
                stall_if_id = 1'b1;
                bubble_ex   = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_s = 2'd0;
        fwd_t = 2'd0;
        if (FWD_EN) begin
            fwd_s = fwd_sel(ex_q.use_s, ex_q.rs);
            fwd_t = fwd_sel(ex_q.use_t, ex_q.rt);
        end
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!mem_stall) begin
            wb_d  = mem_q;
            mem_d = ex_q.w;
            ex_d  = '0;
            if (id_valid & !bubble_ex & !squash_id) begin
                ex_d.w.valid = 1'b1;
                ex_d.w.wreg  = id_wreg;
                ex_d.w.wen   = id_wen;
                ex_d.load    = id_load;
                ex_d.rs      = id_rs;
                ex_d.rt      = id_rt;
                ex_d.use_s   = id_use_s;
                ex_d.use_t   = id_use_t;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign wb_wreg = wb_q.valid ? wb_q.wreg : '0;
    assign wb_wen  = wb_q.valid & wb_q.wen;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: forwarding DUT plus a FWD_EN=0 DUT on shared inputs.
module tb_ex_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_s, id_use_t, id_wen, id_load, flush, mem_stall;
    logic [4:0] id_rs, id_rt, id_wreg;

    logic       stall_if_id, bubble_ex, squash_id, wb_wen;
    logic [1:0] fwd_s, fwd_t;
    logic [4:0] wb_wreg;
    logic       n_stall_if_id, n_bubble_ex, n_squash_id, n_wb_wen;
    logic [1:0] n_fwd_s, n_fwd_t;
    logic [4:0] n_wb_wreg;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.REG_W(5), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_s(id_use_s), .id_use_t(id_use_t), .id_wreg(id_wreg), .id_wen(id_wen),
        .id_load(id_load), .flush(flush), .mem_stall(mem_stall),
        .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .squash_id(squash_id),
        .fwd_s(fwd_s), .fwd_t(fwd_t), .wb_wreg(wb_wreg), .wb_wen(wb_wen)
    );

    ex_hazard_ctrl #(.REG_W(5), .FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_s(id_use_s), .id_use_t(id_use_t), .id_wreg(id_wreg), .id_wen(id_wen),
        .id_load(id_load), .flush(flush), .mem_stall(mem_stall),
        .stall_if_id(n_stall_if_id), .bubble_ex(n_bubble_ex), .squash_id(n_squash_id),
        .fwd_s(n_fwd_s), .fwd_t(n_fwd_t), .wb_wreg(n_wb_wreg), .wb_wen(n_wb_wen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic us, input logic ut, input logic [4:0] w,
                          input logic we, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_s = us; id_use_t = ut;
        id_wreg = w; id_wen = we; id_load = ld;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b1; mem_stall = 1'b1;
        idle();
        settle();
        chk("rst_stall", stall_if_id, 0);
        chk("rst_bubble", bubble_ex, 0);
        chk("rst_squash", squash_id, 0);
        chk("rst_fwd_s", fwd_s, 0);
        chk("rst_fwd_t", fwd_t, 0);
        chk("rst_wb_wreg", wb_wreg, 0);
        chk("rst_wb_wen", wb_wen, 0);
        tick(); tick();
        rst = 1'b0; flush = 1'b0; mem_stall = 1'b0;

        // add r3,r1,r2 ; sub r4,r3,r3
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); settle();
        chk("a_stall", stall_if_id, 0);
        tick(); set_id(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0); settle();
        chk("b_stall", stall_if_id, 0);
        chk("b_bubble", bubble_ex, 0);
        tick(); idle(); settle();
        chk("c_fwd_s_mem", fwd_s, 1);
        chk("c_fwd_t_mem", fwd_t, 1);
        // add r3 ; nop ; or r5,r3,r1
        tick(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); settle();
        chk("d_wb_wreg", wb_wreg, 3);
        chk("d_wb_wen", wb_wen, 1);
        tick(); idle(); settle();
        tick(); set_id(1, 5'd3, 5'd1, 1, 1, 5'd5, 1, 0); settle();
        tick(); idle(); settle();
        chk("g_fwd_s_wb", fwd_s, 2);
        chk("g_fwd_t_none", fwd_t, 0);

        // lw r7 ; add r8,r7,r2
        tick(); set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1); settle();
        tick(); set_id(1, 5'd7, 5'd2, 1, 1, 5'd8, 1, 0); settle();
        chk("i_lu_stall", stall_if_id, 1);
        chk("i_lu_bubble", bubble_ex, 1);
        tick(); settle();
        chk("j_lu_stall_done", stall_if_id, 0);
        chk("j_lu_bubble_done", bubble_ex, 0);
        tick(); idle(); settle();
        chk("k_lu_fwd_s", fwd_s, 2);
        chk("k_lu_fwd_t", fwd_t, 0);
        chk("k_wb_wreg", wb_wreg, 7);
        chk("k_wb_wen", wb_wen, 1);

        // add r0,r1,r2 ; use r0 ; lw r0 ; use r0
        tick(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0); settle();
        tick(); set_id(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0); settle();
        chk("m_r0_stall", stall_if_id, 0);
        tick(); set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1); settle();
        chk("n_r0_fwd_s", fwd_s, 0);
        chk("n_r0_fwd_t", fwd_t, 0);
        tick(); set_id(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0); settle();
        chk("o_ld_r0_stall", stall_if_id, 0);
        chk("o_ld_r0_bubble", bubble_ex, 0);

        // lw r9 ; add r10,r9 squashed by flush in the same cycle
        tick(); set_id(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1); settle();
        tick(); set_id(1, 5'd9, 5'd0, 1, 0, 5'd10, 1, 0); flush = 1'b1; settle();
        chk("q_fl_squash", squash_id, 1);
        chk("q_fl_stall", stall_if_id, 0);
        chk("q_fl_bubble", bubble_ex, 0);
        tick(); flush = 1'b0; set_id(1, 5'd10, 5'd10, 1, 1, 5'd5, 1, 0); settle();
        chk("r_fl_stall", stall_if_id, 0);
        tick(); idle(); settle();
        chk("s_fl_fwd_s", fwd_s, 0);
        chk("s_fl_fwd_t", fwd_t, 0);
        chk("s_fl_wb_wreg", wb_wreg, 9);

        // add r11 ; sub r12,r11,r11 ; then 3 cycles of mem_stall with flush held
        tick(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd11, 1, 0); settle();
        tick(); set_id(1, 5'd11, 5'd11, 1, 1, 5'd12, 1, 0); settle();
        tick(); set_id(1, 5'd12, 5'd0, 1, 0, 5'd13, 1, 0); mem_stall = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ms_stall", stall_if_id, 1);
            chk("ms_bubble", bubble_ex, 0);
            chk("ms_squash", squash_id, 0);
            chk("ms_fwd_s", fwd_s, 1);
            chk("ms_fwd_t", fwd_t, 1);
            chk("ms_wb_wen", wb_wen, 0);
            tick();
        end
        mem_stall = 1'b0; flush = 1'b0; idle(); settle();
        chk("y_fwd_s_held", fwd_s, 1);
        chk("y_stall", stall_if_id, 0);
        tick(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd13, 1, 0); settle();
        chk("z_wb_wreg", wb_wreg, 11);
        chk("z_wb_wen", wb_wen, 1);

        // reset with add r13 in MEM and add r14 in EX
        tick(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd14, 1, 0); settle();
        tick(); rst = 1'b1; settle();
        chk("mr_wb_wen", wb_wen, 0);
        chk("mr_wb_wreg", wb_wreg, 0);
        chk("mr_fwd_s", fwd_s, 0);
        tick(); rst = 1'b0; idle();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mr_after_wb_wen", wb_wen, 0);
            tick();
        end

        // no-forwarding variant: add r3 ; use r3 -> two stall cycles
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); settle();
        chk("nf_c1_stall", n_stall_if_id, 0);
        tick(); set_id(1, 5'd3, 5'd1, 1, 1, 5'd6, 1, 0); settle();
        chk("nf_c2_stall", n_stall_if_id, 1);
        chk("nf_c2_bubble", n_bubble_ex, 1);
        chk("fw_c2_stall", stall_if_id, 0);
        tick(); settle();
        chk("nf_c3_stall", n_stall_if_id, 1);
        chk("fw_c3_fwd_s", fwd_s, 1);
        tick(); settle();
        chk("nf_c4_stall", n_stall_if_id, 0);
        chk("nf_c4_wb_wreg", n_wb_wreg, 3);
        tick(); idle(); settle();
        chk("nf_c5_fwd_s", n_fwd_s, 0);
        chk("nf_c5_fwd_t", n_fwd_t, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
